alu_issue_ctrl: RTL and testbench

//  Issue side of the ALU interface. Accepts one MIPS instruction plus register operands and decodes it to
//  alu_control/shamt/operands, then drives the registered ALU (1-cycle result latency).

---
 rtl/alu_ctrl_pkg.sv | 50 +++++
 rtl/alu_issue_decode.sv | 87 ++++++++
 rtl/alu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: ALU op codes, MIPS opcode/funct
// fields and the issue FSM state type.
package alu_ctrl_pkg;

   localparam logic [3:0] AluNop  = 4'b0000;
   localparam logic [3:0] AluAdd  = 4'b0010;
   localparam logic [3:0] AluSub  = 4'b0011;
   localparam logic [3:0] AluAnd  = 4'b0100;
   localparam logic [3:0] AluOr   = 4'b0101;
   localparam logic [3:0] AluXor  = 4'b0110;
   localparam logic [3:0] AluNot  = 4'b0111;
   localparam logic [3:0] AluSll  = 4'b1000;
   localparam logic [3:0] AluSrl  = 4'b1001;
   localparam logic [3:0] AluNor  = 4'b1010;
   localparam logic [3:0] AluSubu = 4'b1011;
   localparam logic [3:0] AluAddu = 4'b1100;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAddiu = 6'b001001;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;

   localparam logic [5:0] FnSll  = 6'b000000;
   localparam logic [5:0] FnSrl  = 6'b000010;
   localparam logic [5:0] FnAdd  = 6'b100000;
   localparam logic [5:0] FnAddu = 6'b100001;
   localparam logic [5:0] FnSub  = 6'b100010;
   localparam logic [5:0] FnSubu = 6'b100011;
   localparam logic [5:0] FnAnd  = 6'b100100;
   localparam logic [5:0] FnOr   = 6'b100101;
   localparam logic [5:0] FnXor  = 6'b100110;
   localparam logic [5:0] FnNor  = 6'b100111;
   localparam logic [5:0] FnSlt  = 6'b101010;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StExec    = 2'b01,
      StCapture = 2'b10
   } state_e;

   // Word-aligned branch displacement; the caller adds it to pc_plus4 modulo 2^32.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: selects ALU op code, operands, shift amount, destination
// register and the flags the issue FSM needs to post-process the ALU result.
module alu_issue_decode
   import alu_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [3:0]  alu_control,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [4:0]  shamt,
   output logic [4:0]  dest,
   output logic        writes,
   output logic        is_branch,
   output logic        is_bne,
   output logic        is_slt,
   output logic        chk_ovf,
   output logic        illegal
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        unused_rs_field;

   assign opcode   = instr[31:26];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext = {16'h0000, instr[15:0]};
   // Operand values arrive already read from the register file.
   assign unused_rs_field = ^instr[25:21];

   always_comb begin
      alu_control = AluNop;
      op_a        = rs_data;
      op_b        = rt_data;
      shamt       = 5'd0;
      dest        = instr[20:16];
      writes      = 1'b0;
      is_branch   = 1'b0;
      is_bne      = 1'b0;
      is_slt      = 1'b0;
      chk_ovf     = 1'b0;
      illegal     = 1'b0;
      case (opcode)
         OpRtype: begin
            dest   = instr[15:11];
            writes = 1'b1;
            case (funct)
               FnAdd:  begin alu_control = AluAdd; chk_ovf = 1'b1; end
               FnAddu: alu_control = AluAddu;
               FnSub:  begin alu_control = AluSub; chk_ovf = 1'b1; end
               FnSubu: alu_control = AluSubu;
               FnAnd:  alu_control = AluAnd;
               FnOr:   alu_control = AluOr;
               FnXor:  alu_control = AluXor;
               FnNor:  alu_control = AluNor;
               FnSlt:  begin alu_control = AluSub; is_slt = 1'b1; end
               FnSll, FnSrl: begin
                  alu_control = (funct == FnSll) ? AluSll : AluSrl;
                  op_a        = rt_data;
                  op_b        = 32'h0;
                  shamt       = instr[10:6];
               end
               default: begin
                  writes  = 1'b0;
                  illegal = 1'b1;
               end
            endcase
         end
         OpAddi:  begin alu_control = AluAdd;  op_b = imm_sext; writes = 1'b1; chk_ovf = 1'b1; end
         OpAddiu: begin alu_control = AluAddu; op_b = imm_sext; writes = 1'b1; end
         OpAndi:  begin alu_control = AluAnd;  op_b = imm_zext; writes = 1'b1; end
         OpOri:   begin alu_control = AluOr;   op_b = imm_zext; writes = 1'b1; end
         OpXori:  begin alu_control = AluXor;  op_b = imm_zext; writes = 1'b1; end
         OpBeq, OpBne: begin
            alu_control = AluSub;
            is_branch   = 1'b1;
            is_bne      = (opcode == OpBne);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue side of the ALU interface: accepts one instruction, drives the registered ALU and
// turns its result into writeback, branch-resolution and exception pulses (3 cycles/instr).
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter bit TRAP_ON_OVERFLOW = 1'b1,
   parameter bit ALLOW_R0_WRITE   = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [31:0] pc_plus4,
   output logic [31:0] alu_op_a,
   output logic [31:0] alu_op_b,
   output logic [3:0]  alu_control,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        alu_less,
   input  logic        alu_overflow,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        branch_valid,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        exc_overflow,
   output logic        illegal_instr
);

   logic [3:0]  dec_control;
   logic [31:0] dec_op_a;
   logic [31:0] dec_op_b;
   logic [4:0]  dec_shamt;
   logic [4:0]  dec_dest;
   logic        dec_writes;
   logic        dec_is_branch;
   logic        dec_is_bne;
   logic        dec_is_slt;
   logic        dec_chk_ovf;
   logic        dec_illegal;

   alu_issue_decode u_decode (
      .instr       (instr),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .alu_control (dec_control),
      .op_a        (dec_op_a),
      .op_b        (dec_op_b),
      .shamt       (dec_shamt),
      .dest        (dec_dest),
      .writes      (dec_writes),
      .is_branch   (dec_is_branch),
      .is_bne      (dec_is_bne),
      .is_slt      (dec_is_slt),
      .chk_ovf     (dec_chk_ovf),
      .illegal     (dec_illegal)
   );

   state_e      state_q;
   logic [4:0]  dest_q;
   logic        writes_q;
   logic        is_branch_q;
   logic        is_bne_q;
   logic        is_slt_q;
   logic        chk_ovf_q;
   logic        illegal_q;
   logic [31:0] target_q;
   logic        trap;
   logic        dest_ok;

   assign trap    = TRAP_ON_OVERFLOW && chk_ovf_q && alu_overflow;
   assign dest_ok = ALLOW_R0_WRITE || (dest_q != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         instr_ready   <= 1'b1;
         alu_op_a      <= 32'h0;
         alu_op_b      <= 32'h0;
         alu_control   <= AluNop;
         alu_shamt     <= 5'd0;
         dest_q        <= 5'd0;
         writes_q      <= 1'b0;
         is_branch_q   <= 1'b0;
         is_bne_q      <= 1'b0;
         is_slt_q      <= 1'b0;
         chk_ovf_q     <= 1'b0;
         illegal_q     <= 1'b0;
         target_q      <= 32'h0;
         wb_valid      <= 1'b0;
         wb_reg        <= 5'd0;
         wb_data       <= 32'h0;
         branch_valid  <= 1'b0;
         branch_taken  <= 1'b0;
         branch_target <= 32'h0;
         exc_overflow  <= 1'b0;
         illegal_instr <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               wb_valid      <= 1'b0;
               branch_valid  <= 1'b0;
               exc_overflow  <= 1'b0;
               illegal_instr <= 1'b0;
               if (instr_valid && instr_ready) begin
                  alu_op_a    <= dec_op_a;
                  alu_op_b    <= dec_op_b;
                  alu_control <= dec_control;
                  alu_shamt   <= dec_shamt;
                  dest_q      <= dec_dest;
                  writes_q    <= dec_writes;
                  is_branch_q <= dec_is_branch;
                  is_bne_q    <= dec_is_bne;
                  is_slt_q    <= dec_is_slt;
                  chk_ovf_q   <= dec_chk_ovf;
                  illegal_q   <= dec_illegal;
                  target_q    <= pc_plus4 + branch_offset(instr[15:0]);
                  instr_ready <= 1'b0;
                  state_q     <= StExec;
               end
            end
            StExec: state_q <= StCapture;
            StCapture: begin
               wb_valid      <= writes_q && !trap && dest_ok;
               wb_reg        <= dest_q;
               wb_data       <= is_slt_q ? {31'b0, alu_less} : alu_result;
               branch_valid  <= is_branch_q;
               branch_taken  <= is_branch_q && (is_bne_q ^ alu_zero);
               branch_target <= target_q;
               exc_overflow  <= trap;
               illegal_instr <= illegal_q;
               instr_ready   <= 1'b1;
               state_q       <= StIdle;
            end
            default: begin
               instr_ready <= 1'b1;
               state_q     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: registered ALU stub, directed vector table, hand-written
// reset/back-to-back sequences and randomized instructions against a MIPS-level model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr, rs_data, rt_data, pc_plus4;
   logic [31:0] alu_op_a, alu_op_b;
   logic [3:0]  alu_control;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result;
   logic        alu_zero, alu_less, alu_overflow;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        branch_valid, branch_taken;
   logic [31:0] branch_target;
   logic        exc_overflow, illegal_instr;

   int checks = 0;
   int errors = 0;

   alu_issue_ctrl #(
      .TRAP_ON_OVERFLOW (1'b1),
      .ALLOW_R0_WRITE   (1'b0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .pc_plus4      (pc_plus4),
      .alu_op_a      (alu_op_a),
      .alu_op_b      (alu_op_b),
      .alu_control   (alu_control),
      .alu_shamt     (alu_shamt),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .alu_less      (alu_less),
      .alu_overflow  (alu_overflow),
      .wb_valid      (wb_valid),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .branch_valid  (branch_valid),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .exc_overflow  (exc_overflow),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   // Registered ALU: result appears the cycle after the sampling edge.
   always @(posedge clk) begin
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (alu_control)
         4'b0010: begin r = alu_op_a + alu_op_b;
                  v = (alu_op_a[31] == alu_op_b[31]) && (r[31] != alu_op_a[31]); end
         4'b0011: begin r = alu_op_a - alu_op_b;
                  v = (alu_op_a[31] != alu_op_b[31]) && (r[31] != alu_op_a[31]); end
         4'b0100: r = alu_op_a & alu_op_b;
         4'b0101: r = alu_op_a | alu_op_b;
         4'b0110: r = alu_op_a ^ alu_op_b;
         4'b0111: r = ~alu_op_a;
         4'b1000: r = alu_op_a << alu_shamt;
         4'b1001: r = alu_op_a >> alu_shamt;
         4'b1010: r = ~(alu_op_a | alu_op_b);
         4'b1011: r = alu_op_a - alu_op_b;
         4'b1100: r = alu_op_a + alu_op_b;
         default: r = 32'h0;
      endcase
      alu_result   <= r;
      alu_zero     <= (r == 32'h0);
      alu_less     <= r[31];
      alu_overflow <= v;
   end

   typedef struct packed {
      logic        ill;
      logic        wbv;
      logic [4:0]  wbr;
      logic [31:0] wbd;
      logic        bv;
      logic        bt;
      logic [31:0] btgt;
      logic        exc;
   } exp_t;

   typedef struct {
      logic [31:0] instr, rs, rt, pc;
      logic [3:0]  ctrl;
      logic        chk_opb;
      logic [31:0] opb;
      exp_t        exp;
   } vec_t;

   localparam longint SMax = 64'sd2147483647;
   localparam longint SMin = -64'sd2147483648;

   // Reference: architectural MIPS meaning of the instruction, with slt defined as the
   // sign bit of rs-rt and traps only on signed add/sub/addi overflow.
   function automatic exp_t ref_model(input logic [31:0] i, rs, rt, pc);
      exp_t        e;
      logic [5:0]  op = i[31:26];
      logic [5:0]  fn = i[5:0];
      logic [31:0] se = {{16{i[15]}}, i[15:0]};
      logic [31:0] ze = {16'h0, i[15:0]};
      logic [31:0] d;
      longint      s;
      logic        ovf = 1'b0;
      logic        wr = 1'b1;
      e = '0;
      e.wbr = (op == 6'd0) ? i[15:11] : i[20:16];
      if (op == 6'd0) begin
         case (fn)
            6'h20: begin s = longint'($signed(rs)) + longint'($signed(rt)); ovf = (s > SMax) || (s < SMin); d = rs + rt; end
            6'h21: d = rs + rt;
            6'h22: begin s = longint'($signed(rs)) - longint'($signed(rt)); ovf = (s > SMax) || (s < SMin); d = rs - rt; end
            6'h23: d = rs - rt;
            6'h24: d = rs & rt;
            6'h25: d = rs | rt;
            6'h26: d = rs ^ rt;
            6'h27: d = ~(rs | rt);
            6'h00: d = rt << i[10:6];
            6'h02: d = rt >> i[10:6];
            6'h2a: begin d = rs - rt; d = {31'b0, d[31]}; end
            default: begin e.ill = 1'b1; wr = 1'b0; d = 0; end
         endcase
      end else begin
         case (op)
            6'h08: begin s = longint'($signed(rs)) + longint'($signed(se)); ovf = (s > SMax) || (s < SMin); d = rs + se; end
            6'h09: d = rs + se;
            6'h0c: d = rs & ze;
            6'h0d: d = rs | ze;
            6'h0e: d = rs ^ ze;
            6'h04, 6'h05: begin
               wr = 1'b0; d = 0;
               e.bv = 1'b1;
               e.bt = (op == 6'h04) ? (rs == rt) : (rs != rt);
               e.btgt = pc + se * 4;
            end
            default: begin e.ill = 1'b1; wr = 1'b0; d = 0; end
         endcase
      end
      e.exc = ovf;
      e.wbv = wr && !ovf && (e.wbr != 5'd0);
      e.wbd = d;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic check_result(input string tag, input exp_t got, input exp_t e);
      check({tag, " wb_valid"}, 32'(got.wbv), 32'(e.wbv));
      check({tag, " branch_valid"}, 32'(got.bv), 32'(e.bv));
      check({tag, " exc_overflow"}, 32'(got.exc), 32'(e.exc));
      check({tag, " illegal_instr"}, 32'(got.ill), 32'(e.ill));
      if (e.wbv) begin
         check({tag, " wb_reg"}, 32'(got.wbr), 32'(e.wbr));
         check({tag, " wb_data"}, got.wbd, e.wbd);
      end
      if (e.bv) begin
         check({tag, " branch_taken"}, 32'(got.bt), 32'(e.bt));
         check({tag, " branch_target"}, got.btgt, e.btgt);
      end
   endtask

   function automatic logic [3:0] pulses();
      return {wb_valid, branch_valid, exc_overflow, illegal_instr};
   endfunction

   // Called at a negedge; returns at the negedge in which the result pulses are visible.
   task automatic issue(input logic [31:0] i, rs, rt, pc,
                        output exp_t got, output logic [3:0] ctrl, output logic [31:0] opb);
      int n = 0;
      got = '0; ctrl = 4'hx; opb = 32'hx;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         check("ready_timeout", 32'(instr_ready), 32'd1);
         return;
      end
      instr = i; rs_data = rs; rt_data = rt; pc_plus4 = pc; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      instr = $urandom; rs_data = $urandom; rt_data = $urandom; pc_plus4 = $urandom;
      ctrl = alu_control;
      opb  = alu_op_b;
      check("ready_low_exec", 32'(instr_ready), 32'd0);
      check("no_pulse_exec", 32'(pulses()), 32'd0);
      @(negedge clk);
      check("ready_low_capture", 32'(instr_ready), 32'd0);
      check("no_pulse_capture", 32'(pulses()), 32'd0);
      @(negedge clk);
      check("ready_after_capture", 32'(instr_ready), 32'd1);
      got.ill = illegal_instr; got.wbv = wb_valid; got.wbr = wb_reg; got.wbd = wb_data;
      got.bv = branch_valid; got.bt = branch_taken; got.btgt = branch_target; got.exc = exc_overflow;
   endtask

   function automatic vec_t mkv(input logic [31:0] i, rs, rt, pc, input logic [3:0] ctrl,
                                input logic chk_opb, input logic [31:0] opb,
                                input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd,
                                input logic bv, bt, input logic [31:0] btgt, input logic exc, ill);
      vec_t v;
      v.instr = i; v.rs = rs; v.rt = rt; v.pc = pc; v.ctrl = ctrl; v.chk_opb = chk_opb; v.opb = opb;
      v.exp.ill = ill; v.exp.wbv = wbv; v.exp.wbr = wbr; v.exp.wbd = wbd;
      v.exp.bv = bv; v.exp.bt = bt; v.exp.btgt = btgt; v.exp.exc = exc;
      return v;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'h0;
         3: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 19);
      if (k <= 10 || k == 19) begin
         w[31:26] = 6'd0;
         case (k)
            0: w[5:0] = 6'h20;  1: w[5:0] = 6'h21;  2: w[5:0] = 6'h22;  3: w[5:0] = 6'h23;
            4: w[5:0] = 6'h24;  5: w[5:0] = 6'h25;  6: w[5:0] = 6'h26;  7: w[5:0] = 6'h27;
            8: w[5:0] = 6'h00;  9: w[5:0] = 6'h02;  10: w[5:0] = 6'h2a;
            default: w[5:0] = 6'h08;
         endcase
      end else begin
         case (k)
            11: w[31:26] = 6'h08;  12: w[31:26] = 6'h09;  13: w[31:26] = 6'h0c;
            14: w[31:26] = 6'h0d;  15: w[31:26] = 6'h0e;  16: w[31:26] = 6'h04;
            17: w[31:26] = 6'h05;  default: w[31:26] = 6'h3f;
         endcase
      end
      return w;
   endfunction

   vec_t vecs[14];

   initial begin
      exp_t        got;
      logic [3:0]  ctrl;
      logic [31:0] opb;
      int          seen;

      vecs[0]  = mkv(32'h20080005, 0, 0, 0, 4'b0010, 1, 32'h5, 1, 8, 32'h5, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(32'h0022182A, 32'hFFFFFFFF, 1, 0, 4'b0011, 1, 32'h1, 1, 3, 32'h1, 0, 0, 0, 0, 0);
      vecs[2]  = mkv(32'h0022182A, 1, 32'hFFFFFFFF, 0, 4'b0011, 1, 32'hFFFFFFFF, 1, 3, 32'h0, 0, 0, 0, 0, 0);
      vecs[3]  = mkv(32'h1022FFFE, 7, 7, 32'h100, 4'b0011, 1, 32'h7, 0, 0, 0, 1, 1, 32'hF8, 0, 0);
      vecs[4]  = mkv(32'h1422FFFE, 7, 7, 32'h100, 4'b0011, 1, 32'h7, 0, 0, 0, 1, 0, 32'hF8, 0, 0);
      vecs[5]  = mkv(32'h00222820, 32'h7FFFFFFF, 1, 0, 4'b0010, 1, 32'h1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[6]  = mkv(32'h00222821, 32'h7FFFFFFF, 1, 0, 4'b1100, 1, 32'h1, 1, 5, 32'h80000000, 0, 0, 0, 0, 0);
      vecs[7]  = mkv(32'hFC000000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[8]  = mkv(32'h20000005, 0, 0, 0, 4'b0010, 1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mkv(32'h00022100, 0, 32'hF1, 0, 4'b1000, 0, 0, 1, 4, 32'hF10, 0, 0, 0, 0, 0);
      vecs[10] = mkv(32'h34298001, 32'h10000, 0, 0, 4'b0101, 1, 32'h8001, 1, 9, 32'h18001, 0, 0, 0, 0, 0);
      vecs[11] = mkv(32'h00223022, 32'h80000000, 1, 0, 4'b0011, 1, 32'h1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[12] = mkv(32'h00023FC2, 0, 32'h80000000, 0, 4'b1001, 0, 0, 1, 7, 32'h1, 0, 0, 0, 0, 0);
      vecs[13] = mkv(32'h302AFFFF, 32'h12345678, 0, 0, 4'b0100, 1, 32'hFFFF, 1, 10, 32'h5678, 0, 0, 0, 0, 0);

      reset = 1'b1; instr_valid = 1'b0;
      instr = 0; rs_data = 0; rt_data = 0; pc_plus4 = 0;
      repeat (2) @(negedge clk);
      check("reset ready", 32'(instr_ready), 32'd1);
      check("reset alu_control", 32'(alu_control), 32'd0);
      check("reset operands", alu_op_a | alu_op_b | 32'(alu_shamt), 32'd0);
      check("reset pulses", 32'(pulses()), 32'd0);
      check("reset wb/branch data", wb_data | branch_target | 32'(wb_reg) | 32'(branch_taken), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post-reset ready", 32'(instr_ready), 32'd1);

      // Directed table, issued back-to-back: each accept lands in the previous pulse cycle.
      foreach (vecs[v]) begin
         issue(vecs[v].instr, vecs[v].rs, vecs[v].rt, vecs[v].pc, got, ctrl, opb);
         check($sformatf("vec%0d alu_control", v), 32'(ctrl), 32'(vecs[v].ctrl));
         if (vecs[v].chk_opb) check($sformatf("vec%0d alu_op_b", v), opb, vecs[v].opb);
         check_result($sformatf("vec%0d", v), got, vecs[v].exp);
      end

      // Pulses last exactly one cycle; ALU ports hold their last value while idle.
      @(negedge clk);
      check("pulse width", 32'(pulses()), 32'd0);
      check("idle holds alu_control", 32'(alu_control), 32'(4'b0100));
      check("idle holds alu_op_b", alu_op_b, 32'hFFFF);

      // Reset while in EXEC drops the instruction.
      instr = 32'h20080005; rs_data = 0; rt_data = 0; pc_plus4 = 0; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      check("mid-op ready low", 32'(instr_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("mid-op reset ready", 32'(instr_ready), 32'd1);
      check("mid-op reset alu_control", 32'(alu_control), 32'd0);
      check("mid-op reset operands", alu_op_a | alu_op_b, 32'd0);
      check("mid-op reset wb", wb_data | 32'(wb_reg), 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (pulses() != 4'd0) seen++;
      end
      check("no pulse after reset", 32'(seen), 32'd0);

      // Randomized instructions against the reference model.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ri, ra, rb, rp;
         ri = rand_instr();
         ra = rand_operand();
         rb = ($urandom_range(0, 3) == 0) ? ra : rand_operand();
         rp = $urandom;
         issue(ri, ra, rb, rp, got, ctrl, opb);
         check_result($sformatf("rand%0d instr=%h rs=%h rt=%h", n, ri, ra, rb),
                      got, ref_model(ri, ra, rb, rp));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
